id_hazard_unit: RTL
===================

# id_hazard_unit

Decode-stage hazard controller for the five-stage pipeline. It sits beside the ID stage and directly upstream of the ID/EX pipeline register. It owns the `zero_control_signals` input of that register, and it also drives the PC/IF-ID hold and IF-ID flush. It tracks in-flight register writes in a three-slot scoreboard and stalls decode on read-after-write hazards; the pipeline has no forwarding. It also sequences flushes on taken branches or jumps and drains the pipeline on HALT.

## Interface
Parameters:
- `WB_BYPASS`, default 1: register file forwards a same-cycle writeback to a read, so the WB slot is not compared.
- `CNT_W`, default 16: width of the stall performance counter.

Ports:
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: reset, asynchronous and active-low (asserted at 0).
- `Rs_id`, `Rt_id`  in  3 each: source registers of the instruction in ID.
- `Rs_valid_id`, `Rt_valid_id`  in  1 each: source register is actually read.
- `write_reg_id`  in  3: destination register of the instruction in ID.
- `reg_write_id`  in  1: instruction in ID writes the register file.
- `halt_id`  in  1: instruction in ID is HALT.
- `redirect_ex`  in  1: taken branch or jump resolved in EX this cycle.
- `stall`  out  1: hold PC and IF/ID this cycle.
- `zero_control_signals`  out  1: turn the ID→EX transfer into a bubble.
- `if_id_flush`  out  1: load a NOP into IF/ID at the next edge.
- `halt_done`  out  1: pipeline fully drained after HALT (registered, sticky).
- `stall_count`  out  CNT_W: count of hazard-stall cycles (registered, saturating).

## Operation
- Scoreboard slots EX, MEM and WB each hold {valid, dest[2:0]}. They shift every cycle: WB←MEM, MEM←EX, EX←entry.
- The entry is {reg_write_id, write_reg_id}, forced invalid whenever `zero_control_signals` is asserted.
- A hazard exists when (`Rs_valid_id` and some valid slot's dest == `Rs_id`) or the same holds for `Rt`.
  - Slots compared: EX and MEM; WB is compared only when `WB_BYPASS`=0.
  - R0 is not special; all 8 registers are compared.
- Outputs are combinational from registered state plus current inputs.
  - `stall` = hazard & ~`redirect_ex`, or state ≠ RUN.
  - `zero_control_signals` = hazard | `redirect_ex` | state ≠ RUN.
  - `if_id_flush` = `redirect_ex`.
- Priority: a redirect beats a hazard. The instruction in ID is on the wrong path, so it is killed rather than held.
- State machine (registered):
  - RUN: if `halt_id` & ~hazard & ~`redirect_ex`, the HALT itself passes into EX and the state goes to DRAIN.
  - DRAIN: fetch is held and bubbles are inserted. When all three slots are invalid and the HALT has left WB, tracked by a 2-bit drain counter loaded with 3 on entry and decremented each cycle, the state goes to HALTED.
  - HALTED: terminal. `halt_done`=1; `stall` and `zero_control_signals` stay at 1. Only reset exits.
- `stall_count` increments on each cycle with hazard & ~`redirect_ex` in RUN and saturates at all-ones. It does not increment in DRAIN or HALTED.
- A `redirect_ex` in the cycle HALT is in ID cancels the HALT; the state stays RUN.

## Timing
- Reset (`rst`=0, asynchronous): all slots invalid, state RUN, drain counter 0, `halt_done`=0, `stall_count`=0.
- With an empty scoreboard and no redirect, all combinational outputs are 0. Release of `rst` is synchronous to `clk`.
- Zero-latency control: `stall` and `zero_control_signals` are valid in the same cycle as the ID fields they depend on.
- Producer followed directly by a dependent instruction: 2 stall cycles with `WB_BYPASS`=1, 3 with `WB_BYPASS`=0.
- HALT: it enters DRAIN on the edge where it leaves ID, and `halt_done` rises exactly 3 edges later.
- A reset asserted mid-stall or mid-DRAIN clears everything immediately. After release, the next instruction sees no hazard.

## Structure
- Shared pipeline package: the state encoding (RUN=2'b00, DRAIN=2'b01, HALTED=2'b10), the register-index width 3, and the drain depth constant 3.
- One natural sub-module, `hazard_scoreboard`: the three-slot shift register plus the comparators. Its outputs are `hazard` and `empty`.
- The FSM and the counter live in the top level.

## Test plan
- ADD writes R3, next instruction reads Rs=R3 (`WB_BYPASS`=1) → `stall`=1 and `zero_control_signals`=1 for exactly 2 cycles, then 0. `stall_count`=2.
- Same sequence, but Rs_valid=0 and Rt=R3 with Rt_valid=1 → identical 2-cycle stall. With both valids 0 → no stall.
- Hazard in ID while `redirect_ex`=1 → `stall`=0, `zero_control_signals`=1, `if_id_flush`=1. Next cycle the EX slot is invalid and `stall_count` is unchanged.
- HALT with an empty pipeline → DRAIN, and `halt_done`=1 three cycles later. `stall`=1 from the cycle after HALT leaves ID onward.
- HALT in ID with `redirect_ex`=1 → state stays RUN and `halt_done` stays 0.
- Force 70000 back-to-back hazard cycles (`CNT_W`=16) → `stall_count` saturates at 16'hFFFF. Then `rst`=0 mid-stall → all outputs 0 asynchronously, before the next edge.

Source files
------------

// File: rtl/id_hazard_unit_pkg.sv
// Shared decode-stage constants: FSM encoding, register index width, drain depth
// and the scoreboard entry layout.
package id_hazard_unit_pkg;

    localparam int REG_W = 3;

    localparam logic [1:0] ST_RUN    = 2'b00;
    localparam logic [1:0] ST_DRAIN  = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    localparam logic [1:0] DRAIN_DEPTH = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
    } sb_slot_t;

endpackage

// File: rtl/id_hazard_unit_if.sv
// Decode-side bundle between the ID stage and its hazard controller.
interface id_hazard_unit_if
    import id_hazard_unit_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] Rs_id;
    logic [REG_W-1:0] Rt_id;
    logic             Rs_valid_id;
    logic             Rt_valid_id;
    logic [REG_W-1:0] write_reg_id;
    logic             reg_write_id;
    logic             halt_id;
    logic             redirect_ex;
    logic             stall;
    logic             zero_control_signals;
    logic             if_id_flush;
    logic             halt_done;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output Rs_id, Rt_id, Rs_valid_id, Rt_valid_id, write_reg_id,
               reg_write_id, halt_id, redirect_ex,
        input  stall, zero_control_signals, if_id_flush, halt_done, stall_count
    );

    modport slave (
        input  Rs_id, Rt_id, Rs_valid_id, Rt_valid_id, write_reg_id,
               reg_write_id, halt_id, redirect_ex,
        output stall, zero_control_signals, if_id_flush, halt_done, stall_count
    );
endinterface

// File: rtl/id_hazard_unit_hazard_scoreboard.sv
// Three-slot in-flight write tracker (EX, MEM, WB) with RAW comparators against
// the source registers of the instruction in ID.
module hazard_scoreboard
    import id_hazard_unit_pkg::*;
#(
    parameter int WB_BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  sb_slot_t         entry,
    input  logic [REG_W-1:0] rs,
    input  logic             rs_valid,
    input  logic [REG_W-1:0] rt,
    input  logic             rt_valid,
    output logic             hazard,
    output logic             empty
);

    logic             vld_p0, vld_p1, vld_p2;
    logic [REG_W-1:0] dest_p0, dest_p1, dest_p2;

    function automatic logic raw_hit(input logic             v,
                                     input logic [REG_W-1:0] d,
                                     input logic [REG_W-1:0] s0,
                                     input logic             s0_v,
                                     input logic [REG_W-1:0] s1,
                                     input logic             s1_v);
        return v && ((s0_v && (d == s0)) || (s1_v && (d == s1)));
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= entry.valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        dest_p0 <= entry.dest;
        dest_p1 <= dest_p0;
        dest_p2 <= dest_p1;
    end

    // With a bypassing register file the WB writer is visible to the read in the same cycle.
    assign hazard = raw_hit(vld_p0, dest_p0, rs, rs_valid, rt, rt_valid)
                  | raw_hit(vld_p1, dest_p1, rs, rs_valid, rt, rt_valid)
                  | ((WB_BYPASS == 0) && raw_hit(vld_p2, dest_p2, rs, rs_valid, rt, rt_valid));

    // Nothing left ahead of WB: whatever sits in WB retires at the next edge.
    assign empty = ~vld_p0 & ~vld_p1;

endmodule

// File: rtl/id_hazard_unit.sv
// Decode hazard controller: RAW stalls, redirect flushes and the HALT drain sequence,
// plus a saturating count of hazard-stall cycles.
module id_hazard_unit
    import id_hazard_unit_pkg::*;
#(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    id_hazard_unit_if.slave   bus
);

    logic             hazard;
    logic             empty;
    logic             run;
    logic             zcs;
    logic             hazard_stall;
    sb_slot_t         entry;
    logic [1:0]       state_q;
    logic [1:0]       drain_cnt_q;
    logic             halt_done_q;
    logic [CNT_W-1:0] stall_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign run          = (state_q == ST_RUN);
    // A redirect kills the wrong-path instruction instead of holding it.
    assign hazard_stall = hazard & ~bus.redirect_ex;
    assign zcs          = hazard | bus.redirect_ex | ~run;

    assign entry.valid  = bus.reg_write_id & ~zcs;
    assign entry.dest   = bus.write_reg_id;

    hazard_scoreboard #(
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .entry    (entry),
        .rs       (bus.Rs_id),
        .rs_valid (bus.Rs_valid_id),
        .rt       (bus.Rt_id),
        .rt_valid (bus.Rt_valid_id),
        .hazard   (hazard),
        .empty    (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= 2'd0;
            halt_done_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.halt_id && !hazard && !bus.redirect_ex) begin
                        state_q     <= ST_DRAIN;
                        drain_cnt_q <= DRAIN_DEPTH;
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_q <= drain_cnt_q - 2'd1;
                    // Last count: HALT is in WB and only bubbles sit behind it.
                    if (drain_cnt_q == 2'd1 && empty) begin
                        state_q     <= ST_HALTED;
                        halt_done_q <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halt_done_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (run && hazard_stall) begin
            stall_cnt_q <= sat_inc(stall_cnt_q);
        end
    end

    assign bus.stall                = hazard_stall | ~run;
    assign bus.zero_control_signals = zcs;
    assign bus.if_id_flush          = bus.redirect_ex;
    assign bus.halt_done            = halt_done_q;
    assign bus.stall_count          = stall_cnt_q;

endmodule
